// File: rtl/rr_arbiter8_pkg.sv
// rtl/rr_arbiter8_pkg.sv - shared constants, state encoding and helpers for rr_arbiter8
package rr_arbiter8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter8_prio_enc.sv
// rtl/rr_arbiter8_prio_enc.sv - 8-to-3 priority encoder, highest set bit wins
module rr_arbiter8_prio_enc
  import rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o
);

  // Ascending scan with last-assignment-wins leaves the highest set index.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with registered one-hot grant and hold-time preemption
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pre_q, pre_d;

  logic [N_REQ-1:0] search_vec;
  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked_vec;
  logic [IDX_W-1:0] idx_masked;
  logic [IDX_W-1:0] idx_unmasked;
  logic [IDX_W-1:0] win_idx;
  logic             others;
  logic             owner_req;
  logic             preempt_due;

  // The current owner never competes for its own hand-off.
  assign search_vec  = (state_q == GRANT) ? (req & ~gnt_q) : req;
  assign mask        = (N_REQ'(1) << ptr_q) - N_REQ'(1);
  assign masked_vec  = search_vec & mask;

  rr_arbiter8_prio_enc u_enc_masked (
    .vec_i (masked_vec),
    .idx_o (idx_masked)
  );

  rr_arbiter8_prio_enc u_enc_unmasked (
    .vec_i (search_vec),
    .idx_o (idx_unmasked)
  );

  assign win_idx     = (|masked_vec) ? idx_masked : idx_unmasked;
  assign others      = |search_vec;
  assign owner_req   = |(req & gnt_q);
  assign preempt_due = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST) && owner_req && others;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    pre_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (others) begin
          state_d = GRANT;
          ptr_d   = win_idx;
          cnt_d   = '0;
          gnt_d   = idx_to_onehot(win_idx);
          idx_d   = win_idx;
        end
      end
      GRANT: begin
        if (owner_req && !preempt_due) begin
          if ((MAX_HOLD != 0) && (cnt_q != HOLD_LAST)) cnt_d = cnt_q + CNT_W'(1);
        end else if (others) begin
          // Owner either released or ran out of hold time; hand off with no bubble.
          ptr_d = win_idx;
          cnt_d = '0;
          gnt_d = idx_to_onehot(win_idx);
          idx_d = win_idx;
          pre_d = owner_req;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          gnt_d   = '0;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == GRANT);
  assign preempt   = pre_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - scoreboard bench for rr_arbiter8 with directed vectors
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       pre;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per clock edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid || preempt !== e.pre) begin
          errors++;
          $display("FAIL %s: got gnt=%b idx=%0d valid=%b preempt=%b, expected gnt=%b idx=%0d valid=%b preempt=%b",
                   e.name, gnt, gnt_idx, gnt_valid, preempt, e.gnt, e.idx, e.valid, e.pre);
        end
      end
    end
  end

  // Drive req at a negedge and queue the outputs expected after the next rising edge.
  task automatic step(input logic [7:0] r, input logic v, input logic [2:0] i,
                      input logic p, input string nm);
    exp_t e;
    req     = r;
    e.valid = v;
    e.idx   = i;
    e.pre   = p;
    e.gnt   = v ? (8'b1 << i) : 8'b0;
    e.name  = nm;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(8'h00, 1'b0, 3'd0, 1'b0, "reset_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    // Reset and single request
    step(8'h04, 1'b0, 3'd0, 1'b0, "reset_outputs_zero");
    rst_n = 1'b1;
    step(8'h04, 1'b1, 3'd2, 1'b0, "single_req_grant2");
    step(8'h00, 1'b0, 3'd0, 1'b0, "single_req_release");

    // Round-robin rotation between 7 and 0
    do_reset();
    step(8'h81, 1'b1, 3'd7, 1'b0, "rot_first_7");
    step(8'h81, 1'b1, 3'd7, 1'b0, "rot_hold_7");
    step(8'h01, 1'b1, 3'd0, 1'b0, "rot_then_0");
    step(8'h81, 1'b1, 3'd0, 1'b0, "rot_hold_0");
    step(8'h80, 1'b1, 3'd7, 1'b0, "rot_then_7");
    step(8'h81, 1'b1, 3'd7, 1'b0, "rot_hold_7b");
    step(8'h01, 1'b1, 3'd0, 1'b0, "rot_then_0b");
    step(8'h81, 1'b1, 3'd0, 1'b0, "rot_hold_0b");
    step(8'h00, 1'b0, 3'd0, 1'b0, "rot_idle");

    // Priority order after owner 5
    step(8'h20, 1'b1, 3'd5, 1'b0, "prio_owner5");
    step(8'hCA, 1'b1, 3'd3, 1'b0, "prio_next3");
    step(8'hC2, 1'b1, 3'd1, 1'b0, "prio_next1");
    step(8'hC0, 1'b1, 3'd7, 1'b0, "prio_next7");
    step(8'h40, 1'b1, 3'd6, 1'b0, "prio_next6");
    step(8'h00, 1'b0, 3'd0, 1'b0, "prio_idle");

    // Preemption after four grant cycles
    step(8'h40, 1'b1, 3'd6, 1'b0, "pre_grant6_c1");
    step(8'h44, 1'b1, 3'd6, 1'b0, "pre_grant6_c2");
    step(8'h44, 1'b1, 3'd6, 1'b0, "pre_grant6_c3");
    step(8'h44, 1'b1, 3'd6, 1'b0, "pre_grant6_c4");
    step(8'h44, 1'b1, 3'd2, 1'b1, "pre_handoff2_pulse");
    step(8'h44, 1'b1, 3'd2, 1'b0, "pre_pulse_one_cycle");
    step(8'h40, 1'b1, 3'd6, 1'b0, "pre_regain6");
    step(8'h00, 1'b0, 3'd0, 1'b0, "pre_idle");

    // Lone requester never preempted
    for (int n = 0; n < 40; n++) step(8'h10, 1'b1, 3'd4, 1'b0, "lone_hold4");
    step(8'h00, 1'b0, 3'd0, 1'b0, "lone_idle");

    // Asynchronous reset mid-grant
    step(8'h10, 1'b1, 3'd4, 1'b0, "async_pre_grant4");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_clear: got gnt=%b idx=%0d valid=%b preempt=%b, expected all zero",
               gnt, gnt_idx, gnt_valid, preempt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h03, 1'b1, 3'd1, 1'b0, "async_after_first1");
    step(8'h00, 1'b0, 3'd0, 1'b0, "async_after_idle");

    for (int w = 0; w < 5 && exp_q.size() != 0; w++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
